// File: rtl/turnaround_arbiter.sv
// Two-requester arbiter for one shared resource. An owner change always passes
// through at least TURN_CYCLES grant-free cycles; bursts are bounded under contention.
module turnaround_arbiter #(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       turn_active,
  output logic       last_owner,
  output logic [7:0] switch_cnt
);

  localparam int unsigned TC_W    = $clog2(TURN_CYCLES + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {S_IDLE, S_GNT_A, S_GNT_B, S_TURN} state_e;

  state_e             state_q, state_d;
  logic [TC_W-1:0]    tc_q, tc_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               last_owner_q, last_owner_d;
  logic               owned_q, owned_d;
  logic [CNT_W-1:0]   switch_cnt_q, switch_cnt_d;
  logic               gnt_a_q, gnt_b_q, turn_q;

  logic granting, tc_ok, burst_full, target_b;
  logic other_req, own_req, enter_a, enter_b;

  // tc_d/burst_d include the current cycle, so decisions see the count as of this cycle's end
  always_comb begin
    granting = (state_q == S_GNT_A) || (state_q == S_GNT_B);

    if (granting)                            tc_d = '0;
    else if (tc_q == TC_W'(TURN_CYCLES))     tc_d = tc_q;
    else                                     tc_d = tc_q + TC_W'(1);
    tc_ok = (tc_d == TC_W'(TURN_CYCLES));

    if (!granting)                           burst_d = '0;
    else if (burst_q == BURST_W'(MAX_BURST)) burst_d = burst_q;
    else                                     burst_d = burst_q + BURST_W'(1);
    burst_full = (burst_d == BURST_W'(MAX_BURST));

    state_d   = state_q;
    target_b  = 1'b0;
    other_req = last_owner_q ? req_a : req_b;
    own_req   = last_owner_q ? req_b : req_a;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          target_b = (req_a && req_b) ? ~last_owner_q : req_b;
          if ((target_b == last_owner_q) || tc_ok) state_d = target_b ? S_GNT_B : S_GNT_A;
          else                                     state_d = S_TURN;
        end
      end
      S_GNT_A: begin
        if (req_a && !(req_b && burst_full)) state_d = S_GNT_A;
        else if (req_b)                      state_d = S_TURN;
        else                                 state_d = S_IDLE;
      end
      S_GNT_B: begin
        if (req_b && !(req_a && burst_full)) state_d = S_GNT_B;
        else if (req_a)                      state_d = S_TURN;
        else                                 state_d = S_IDLE;
      end
      S_TURN: begin
        if (other_req) begin
          if (tc_ok) state_d = last_owner_q ? S_GNT_A : S_GNT_B;
        end else if (own_req) begin
          state_d = last_owner_q ? S_GNT_B : S_GNT_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The reset value of last_owner is only a tie-breaker, so the first grant is not a switch
    enter_a      = (state_d == S_GNT_A) && (state_q != S_GNT_A);
    enter_b      = (state_d == S_GNT_B) && (state_q != S_GNT_B);
    last_owner_d = last_owner_q;
    owned_d      = owned_q;
    switch_cnt_d = switch_cnt_q;
    if (enter_a || enter_b) begin
      last_owner_d = enter_b;
      owned_d      = 1'b1;
      if (owned_q && (last_owner_q != enter_b)) switch_cnt_d = switch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tc_q         <= TC_W'(TURN_CYCLES);
      burst_q      <= '0;
      last_owner_q <= 1'b1;
      owned_q      <= 1'b0;
      switch_cnt_q <= '0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      turn_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tc_q         <= tc_d;
      burst_q      <= burst_d;
      last_owner_q <= last_owner_d;
      owned_q      <= owned_d;
      switch_cnt_q <= switch_cnt_d;
      gnt_a_q      <= (state_d == S_GNT_A);
      gnt_b_q      <= (state_d == S_GNT_B);
      turn_q       <= (state_d == S_TURN);
    end
  end

  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign turn_active = turn_q;
  assign last_owner  = last_owner_q;
  assign switch_cnt  = switch_cnt_q;

endmodule

// File: tb/tb_turnaround_arbiter.sv
// Directed bench for turnaround_arbiter: one instance with TURN_CYCLES=1 and one
// with TURN_CYCLES=3, checked against hand-computed per-edge vectors.
module tb_turnaround_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a, req_b, req_a3, req_b3;
  logic       gnt_a, gnt_b, turn_active, last_owner;
  logic       gnt_a3, gnt_b3, turn_active3, last_owner3;
  logic [7:0] switch_cnt, switch_cnt3;

  int n_chk;
  int n_pass;

  turnaround_arbiter #(.TURN_CYCLES(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .turn_active(turn_active),
    .last_owner(last_owner), .switch_cnt(switch_cnt)
  );

  turnaround_arbiter #(.TURN_CYCLES(3), .MAX_BURST(4)) dut3 (
    .clk(clk), .rst(rst), .req_a(req_a3), .req_b(req_b3),
    .gnt_a(gnt_a3), .gnt_b(gnt_b3), .turn_active(turn_active3),
    .last_owner(last_owner3), .switch_cnt(switch_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_excl:   assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
  a_ab:     assert property (@(posedge clk) disable iff (rst) gnt_a |=> !gnt_b);
  a_ba:     assert property (@(posedge clk) disable iff (rst) gnt_b |=> !gnt_a);
  a_excl3:  assert property (@(posedge clk) disable iff (rst) !(gnt_a3 && gnt_b3));
  a_ab3:    assert property (@(posedge clk) disable iff (rst) gnt_a3 |=> !gnt_b3);
  a_ba3:    assert property (@(posedge clk) disable iff (rst) gnt_b3 |=> !gnt_a3);

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // inputs applied before an edge, outputs expected just after it
  typedef struct packed {
    logic       ra, rb, ga, gb, ta, lo;
    logic [7:0] sc;
  } vec_t;

  vec_t v1 [21] = '{
    '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},  // first grant to A
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0},  // burst of 4 spent -> turn
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1},
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2},
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2},
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2},  // turn toward B
    '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2},  // B withdrew: A back, no switch
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3},  // one dead cycle suffices
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3},  // regrant to last owner
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3}
  };

  vec_t v3 [5] = '{
    '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1}
  };

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    req_a  = 1'b0; req_b  = 1'b0;
    req_a3 = 1'b0; req_b3 = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_gnt_a", 8'(gnt_a), 8'd0);
    check("rst_gnt_b", 8'(gnt_b), 8'd0);
    check("rst_turn",  8'(turn_active), 8'd0);
    check("rst_last",  8'(last_owner), 8'd1);
    check("rst_cnt",   switch_cnt, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      req_a = v1[i].ra;
      req_b = v1[i].rb;
      @(posedge clk); #1;
      check($sformatf("v%0d_gnt_a", i), 8'(gnt_a), 8'(v1[i].ga));
      check($sformatf("v%0d_gnt_b", i), 8'(gnt_b), 8'(v1[i].gb));
      check($sformatf("v%0d_turn", i),  8'(turn_active), 8'(v1[i].ta));
      check($sformatf("v%0d_last", i),  8'(last_owner), 8'(v1[i].lo));
      check($sformatf("v%0d_cnt", i),   switch_cnt, v1[i].sc);
    end

    // asynchronous reset in the middle of a B grant
    req_b = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_gnt_b", 8'(gnt_b), 8'd1);
    #2 rst = 1'b1;
    #1;
    check("async_gnt_b", 8'(gnt_b), 8'd0);
    check("async_cnt",   switch_cnt, 8'd0);
    check("async_last",  8'(last_owner), 8'd1);
    @(posedge clk); #1;
    rst   = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    @(posedge clk); #1;
    check("tie_gnt_a", 8'(gnt_a), 8'd1);
    check("tie_gnt_b", 8'(gnt_b), 8'd0);
    check("tie_last",  8'(last_owner), 8'd0);
    check("tie_cnt",   switch_cnt, 8'd0);
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      req_a3 = v3[i].ra;
      req_b3 = v3[i].rb;
      @(posedge clk); #1;
      check($sformatf("t3_%0d_gnt_a", i), 8'(gnt_a3), 8'(v3[i].ga));
      check($sformatf("t3_%0d_gnt_b", i), 8'(gnt_b3), 8'(v3[i].gb));
      check($sformatf("t3_%0d_turn", i),  8'(turn_active3), 8'(v3[i].ta));
      check($sformatf("t3_%0d_last", i),  8'(last_owner3), 8'(v3[i].lo));
      check($sformatf("t3_%0d_cnt", i),   switch_cnt3, v3[i].sc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
